// File: rtl/ser_pkg.sv
// Shared definitions for the bit serializer and the detector testbench.
//   ser_state_e     : serializer control FSM states
//   ser_even_parity : even-parity bit of a word of up to SerMaxWidth bits
//   SER_DEFAULT_WIDTH : default word width shared with the detector bench
package ser_pkg;

  localparam int unsigned SER_DEFAULT_WIDTH = 8;
  localparam int unsigned SerMaxWidth       = 64;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2
  } ser_state_e;

  // Callers zero-extend narrower words; zeros do not change the XOR.
  function automatic logic ser_even_parity(input logic [SerMaxWidth-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/ser_shift_reg.sv
// Loadable shift register feeding the serial output.
//   clk_i       : rising-edge clock
//   rst_ni      : synchronous active-low reset, clears the register
//   load_i      : load load_data_i (wins over shift_i)
//   shift_i     : move contents one place toward the head
//   load_data_i : parallel word to load
//   head_o      : current head bit (MSB when MSB_FIRST, else LSB)
module ser_shift_reg #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] load_data_i,
  output logic             head_o
);

  logic [WIDTH-1:0] sr_d, sr_q;

  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = load_data_i;
    end else if (shift_i) begin
      sr_d = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign head_o = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with valid/ready input handshake.
// Words stream gaplessly one bit per clock on ser_out. Defining SER_PARITY_EN
// appends an even-parity bit after each word (WIDTH+1 bits per word).
//   clk       : rising-edge clock
//   rstn      : synchronous active-low reset
//   in_data   : parallel word, sampled on accept
//   in_valid  : upstream has a word
//   in_ready  : serializer can take a word this cycle
//   ser_out   : serial bit (IDLE_BIT when ser_valid is low)
//   ser_valid : ser_out carries a data or parity bit
//   word_done : pulse on the final bit of each word
//   busy      : state is not idle
module bit_serializer
  import ser_pkg::*;
#(
  parameter int unsigned WIDTH     = SER_DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);

  ser_state_e      state_d, state_q;
  logic [CntW-1:0] cnt_d, cnt_q;
  logic            accept;
  logic            load, shift;
  logic            head;

`ifdef SER_PARITY_EN
  logic par_d, par_q;
`endif

  ser_shift_reg #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_shift_reg (
    .clk_i      (clk),
    .rst_ni     (rstn),
    .load_i     (load),
    .shift_i    (shift),
    .load_data_i(in_data),
    .head_o     (head)
  );

  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      S_IDLE:   in_ready = 1'b1;
`ifdef SER_PARITY_EN
      S_PARITY: in_ready = 1'b1;
`else
      S_SHIFT:  in_ready = (cnt_q == '0);
`endif
      default:  in_ready = 1'b0;
    endcase
    if (!rstn) in_ready = 1'b0;
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    shift   = 1'b0;
`ifdef SER_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          load    = 1'b1;
          cnt_d   = CntMax;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shift = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
`ifdef SER_PARITY_EN
          state_d = S_PARITY;
`else
          // Last bit: a same-edge accept reloads so the next word has no gap.
          if (accept) begin
            load  = 1'b1;
            cnt_d = CntMax;
          end else begin
            state_d = S_IDLE;
          end
`endif
        end
      end
`ifdef SER_PARITY_EN
      S_PARITY: begin
        if (accept) begin
          load    = 1'b1;
          cnt_d   = CntMax;
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
`ifdef SER_PARITY_EN
    if (accept) par_d = ser_even_parity(SerMaxWidth'(in_data));
`endif
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
`ifdef SER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef SER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Outputs depend only on registers, never on in_data directly.
  always_comb begin
    ser_out   = IDLE_BIT;
    ser_valid = 1'b0;
    word_done = 1'b0;
    unique case (state_q)
      S_SHIFT: begin
        ser_out   = head;
        ser_valid = 1'b1;
`ifndef SER_PARITY_EN
        word_done = (cnt_q == '0);
`endif
      end
`ifdef SER_PARITY_EN
      S_PARITY: begin
        ser_out   = par_q;
        ser_valid = 1'b1;
        word_done = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign busy = (state_q != S_IDLE);

endmodule
